io_vend_dev: RTL
================

IO_VEND_DEV -- requirements
Module: io_vend_dev

Interface
REQ-001 Parameter: word_sz, 8, data/address width.
REQ-002 Parameter: tick_div, 16, clock cycles per dispense duration unit.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 address  input  word_sz  IO-space address from the processor's address register.
REQ-007 data_in  input  word_sz  write data from bus_1.
REQ-008 io_write  input  1  IO write strobe; sampled on rising clk.
REQ-009 data_out  output  word_sz  combinational read data for the current address (feeds bus_2 IO channel).
REQ-010 coin_valid  input  1  one-cycle coin-accepted pulse.
REQ-011 coin_value  input  word_sz  coin value, valid with coin_valid.
REQ-012 disp_en  output  4  dispensing-unit enables.
REQ-013 change_pulse  output  1  one-cycle request to eject one change coin.
REQ-014 change_ack  input  1  coin mechanism confirms one ejected coin.
REQ-015 scan_idx  output  4  display scan position.
REQ-016 scan_char  output  word_sz  display character at scan_idx, registered.

Function
REQ-017 Register map: 0x00 CREDIT (R/W), 0x01 STATUS (R/W), 0x02 DISPENSE (W), 0x03 CHANGE (W), 0x04 ABORT (W), 0x10-0x1F DISPLAY[0..15] (R/W); all other addresses read 0, writes ignored.
REQ-018 data_out SHALL be combinational from address (zero-latency read); write-only registers read 0.
REQ-019 STATUS read: bit0 dispense busy, bit1 change busy, bit2 err (sticky), bit3 credit overflow (sticky), bits7:4 zero.
REQ-020 Credit update per cycle: c1 = min(credit + coin_value, 255) if coin_valid else credit; overflow bit set when the unsaturated sum exceeds 255.
REQ-021 Write N to CREDIT: if c1 >= N then credit <= c1 - N, else credit <= c1 and err set; coin and write in the same cycle both take effect.
REQ-022 Write to STATUS: bit2=1 clears err, bit3=1 clears overflow; other bits ignored; a same-cycle set event wins over clear.
REQ-023 Dispense FSM states D_IDLE, D_RUN.
REQ-024 DISPENSE write (mask=data_in[3:0], dur=data_in[7:4]) in D_IDLE with mask!=0 and dur!=0: disp_en <= mask, enter D_RUN; disp_en asserted exactly dur*tick_div cycles starting the cycle after the write; then disp_en <= 0, D_IDLE.
REQ-025 DISPENSE write with mask==0 or dur==0: no action, no error; DISPENSE write in D_RUN: ignored, err set.
REQ-026 ABORT write (any data): disp_en <= 0, D_IDLE next cycle; change FSM unaffected.
REQ-027 Change FSM states C_IDLE, C_PULSE, C_WAIT; remaining counter word_sz bits.
REQ-028 CHANGE write N>0 in C_IDLE: remaining <= N, enter C_PULSE; N==0: no action.
REQ-029 C_PULSE: change_pulse=1 for exactly one cycle, go C_WAIT.
REQ-030 C_WAIT: on change_ack, remaining-1; if result 0 go C_IDLE else C_PULSE; change_ack outside C_WAIT ignored.
REQ-031 CHANGE write while not C_IDLE: ignored, err set; change does not modify credit.
REQ-032 DISPLAY write stores data_in at entry address[3:0]; readable via data_out.
REQ-033 scan_idx increments by 1 every cycle, wrapping 15->0; scan_char <= DISPLAY[scan_idx] registered one cycle behind the index it was read for, scan_idx advanced in the same edge (scan_char pairs with previous scan_idx value).

Reset
REQ-034 On rst=1 at a rising edge: credit=0, err=0, overflow=0, disp_en=0, D_IDLE, C_IDLE, remaining=0, change_pulse=0, scan_idx=0, scan_char=0, all DISPLAY entries=0x00.
REQ-035 Reset SHALL take priority over io_write, coin_valid and change_ack in the same cycle and abort any dispense or change sequence mid-operation.

Verification
REQ-036 Coins 100, 100, 100 in separate cycles -> CREDIT reads 255, STATUS bit3=1; write STATUS 0x08 -> bit3=0.
REQ-037 Credit 50, write CREDIT 60 -> credit stays 50, err=1; write CREDIT 20 with coin_value 5 same cycle -> credit 35.
REQ-038 Write DISPENSE 0x25 -> disp_en=0x5 for exactly 32 cycles, STATUS bit0=1 throughout; second DISPENSE write mid-run -> ignored, err=1.
REQ-039 Write CHANGE 3, ack each pulse after 2 cycles -> exactly 3 change_pulse, then C_IDLE; rst asserted after first ack -> no further pulses, all outputs at reset values.
REQ-040 Write DISPLAY 0x13=0x41 -> reads back 0x41; scan_char=0x41 in the cycle after scan_idx=3 was presented.

Source files
------------

// File: rtl/io_vend_dev.sv
// io_vend_dev: vending IO peripheral with credit, dispense timer, change ejector and display scan
module io_vend_dev #(
  parameter int word_sz = 8,
  parameter int tick_div = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [word_sz-1:0] address,
  input  logic [word_sz-1:0] data_in,
  input  logic               io_write,
  output logic [word_sz-1:0] data_out,
  input  logic               coin_valid,
  input  logic [word_sz-1:0] coin_value,
  output logic [3:0]         disp_en,
  output logic               change_pulse,
  input  logic               change_ack,
  output logic [3:0]         scan_idx,
  output logic [word_sz-1:0] scan_char
);
  localparam int cw = $clog2(15 * tick_div + 1);
  typedef enum logic {D_IDLE, D_RUN} d_state_t;
  typedef enum logic [1:0] {C_IDLE, C_PULSE, C_WAIT} c_state_t;
  d_state_t d_state;
  c_state_t c_state;
  logic [cw-1:0] dcnt;
  logic [word_sz-1:0] credit, remaining, c1, credit_nxt, status;
  logic [word_sz-1:0] disp_mem [16];
  logic [word_sz:0] sum;
  logic err, ovf, set_err, under, is_disp;
  logic wr_credit, wr_status, wr_dispense, wr_change, wr_abort;
  assign is_disp     = address[word_sz-1:4] == (word_sz-4)'(1);
  assign wr_credit   = io_write && address == word_sz'(0);
  assign wr_status   = io_write && address == word_sz'(1);
  assign wr_dispense = io_write && address == word_sz'(2);
  assign wr_change   = io_write && address == word_sz'(3);
  assign wr_abort    = io_write && address == word_sz'(4);
  // Saturating coin accumulation followed by an optional purchase debit
  always_comb begin
    sum        = {1'b0, credit} + (coin_valid ? {1'b0, coin_value} : '0);
    c1         = sum[word_sz] ? '1 : sum[word_sz-1:0];
    under      = wr_credit && c1 < data_in;
    credit_nxt = (wr_credit && !under) ? c1 - data_in : c1;
    set_err    = under || (wr_dispense && d_state == D_RUN) || (wr_change && c_state != C_IDLE);
    status     = {{(word_sz-4){1'b0}}, ovf, err, c_state != C_IDLE, d_state == D_RUN};
    data_out   = address == word_sz'(0) ? credit :
                 address == word_sz'(1) ? status :
                 is_disp ? disp_mem[address[3:0]] : '0;
  end
  // Credit and sticky flags; a set event in the same cycle beats a clear
  always_ff @(posedge clk) begin
    if (rst) begin
      credit <= '0;
      err    <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      credit <= credit_nxt;
      err    <= set_err || (err && !(wr_status && data_in[2]));
      ovf    <= sum[word_sz] || (ovf && !(wr_status && data_in[3]));
    end
  end
  // Dispense FSM: holds the unit mask for dur*tick_div cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      d_state <= D_IDLE;
      disp_en <= '0;
      dcnt    <= '0;
    end else if (wr_abort) begin
      d_state <= D_IDLE;
      disp_en <= '0;
    end else if (d_state == D_IDLE) begin
      if (wr_dispense && data_in[3:0] != 4'd0 && data_in[7:4] != 4'd0) begin
        d_state <= D_RUN;
        disp_en <= data_in[3:0];
        dcnt    <= cw'(data_in[7:4] * tick_div - 1);
      end
    end else if (dcnt == '0) begin
      d_state <= D_IDLE;
      disp_en <= '0;
    end else
      dcnt <= dcnt - 1'b1;
  end
  // Change FSM: one pulse per coin, then wait for the mechanism to confirm it
  always_ff @(posedge clk) begin
    if (rst) begin
      c_state      <= C_IDLE;
      remaining    <= '0;
      change_pulse <= 1'b0;
    end else case (c_state)
      C_IDLE: if (wr_change && data_in != '0) begin
        remaining    <= data_in;
        c_state      <= C_PULSE;
        change_pulse <= 1'b1;
      end
      C_PULSE: begin
        c_state      <= C_WAIT;
        change_pulse <= 1'b0;
      end
      C_WAIT: if (change_ack) begin
        remaining    <= remaining - 1'b1;
        c_state      <= remaining == word_sz'(1) ? C_IDLE : C_PULSE;
        change_pulse <= remaining != word_sz'(1);
      end
      default: c_state <= C_IDLE;
    endcase
  end
  // Display memory and scan; scan_char lags the index it was fetched for by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) disp_mem[i] <= '0;
      scan_idx  <= '0;
      scan_char <= '0;
    end else begin
      if (io_write && is_disp) disp_mem[address[3:0]] <= data_in;
      scan_idx  <= scan_idx + 1'b1;
      scan_char <= disp_mem[scan_idx];
    end
  end
endmodule
